// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register
// offsets, CTRL bit positions, MODE codes, FSM states and the byte-lane helper.
package timer_device_pkg;

    // Word offsets within the device (PrAddr[3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // CTRL layout; bits above CTRL_W-1 read as zero and ignore writes
    localparam int CTRL_W        = 4;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // MODE codes; 1x decodes as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Expand a 4-bit byte enable into a 32-bit lane mask
    function automatic logic [31:0] byte_mask(input logic [3:0] mask);
        logic [31:0] lanes;
        lanes = 32'd0;
        for (int i = 0; i < 4; i++) begin
            lanes[8*i +: 8] = {8{mask[i]}};
        end
        return lanes;
    endfunction

endpackage

// File: rtl/timer_device_if.sv
// Processor-side bus slice between Bridge and one timer instance.
interface timer_device_if;
    logic        Sel;
    logic [1:0]  Addr;
    logic        WE;
    logic [3:0]  Mask;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        IRQ;

    modport master (
        output Sel, Addr, WE, Mask, WData,
        input  RData, IRQ
    );

    modport slave (
        input  Sel, Addr, WE, Mask, WData,
        output RData, IRQ
    );
endinterface

// File: rtl/timer_device_byte_merge.sv
// Byte-enable merge of a write word into an existing register value; shared
// by Bridge-side devices that support partial writes.
module byte_merge
    import timer_device_pkg::*;
(
    input  logic [31:0] old_data,
    input  logic [31:0] new_data,
    input  logic [3:0]  mask,
    output logic [31:0] merged
);

    // Enabled lanes take the new byte, the rest keep the old one
    always_comb begin
        merged = (new_data & byte_mask(mask)) | (old_data & ~byte_mask(mask));
    end

endmodule

// File: rtl/timer_device.sv
// Programmable down-counter timer with CTRL/PRESET/COUNT registers and a
// level interrupt. The FSM walks IDLE -> LOAD -> CNT -> INT; auto-reload
// mode loops back through LOAD, one-shot mode drops EN and parks in IDLE.
module timer_device
    import timer_device_pkg::*;
#(
    parameter int              CNT_W       = 32,
    parameter logic [CNT_W-1:0] PRESET_INIT = {CNT_W{1'b0}}
) (
    input logic           Clk,
    input logic           Rst,
    timer_device_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CTRL_W-1:0] ctrl_r;
    logic [CNT_W-1:0]  preset_r;
    logic [CNT_W-1:0]  count_r;
    logic              irq_flag_r;
    state_t            state_r;

    state_t            state_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              irq_set_s;
    logic              irq_clr_fsm_s;
    logic              en_clr_fsm_s;

    logic              wr_s;
    logic              wr_ctrl_s;
    logic              wr_preset_s;
    logic [31:0]       ctrl_ext_s;
    logic [31:0]       preset_ext_s;
    logic [31:0]       count_ext_s;
    logic [31:0]       merge_old_s;
    logic [31:0]       merged_s;
    logic              en_s;
    logic              reload_s;

    // Zero-extended register views and write decode
    always_comb begin
        ctrl_ext_s   = {{(32-CTRL_W){1'b0}}, ctrl_r};
        preset_ext_s = 32'(preset_r);
        count_ext_s  = 32'(count_r);
        wr_s         = bus.WE & bus.Sel;
        wr_ctrl_s    = wr_s & (bus.Addr == ADDR_CTRL);
        wr_preset_s  = wr_s & (bus.Addr == ADDR_PRESET);
        if (bus.Addr == ADDR_CTRL) begin
            merge_old_s = ctrl_ext_s;
        end else begin
            merge_old_s = preset_ext_s;
        end
        en_s     = ctrl_r[CTRL_EN_BIT];
        reload_s = (ctrl_r[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);
    end

    byte_merge u_merge (
        .old_data (merge_old_s),
        .new_data (bus.WData),
        .mask     (bus.Mask),
        .merged   (merged_s)
    );

    // FSM next-state and counter datapath
    always_comb begin
        state_nxt_s   = state_r;
        count_nxt_s   = count_r;
        irq_set_s     = 1'b0;
        irq_clr_fsm_s = 1'b0;
        en_clr_fsm_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (en_s) begin
                    count_nxt_s = preset_r;
                    state_nxt_s = ST_CNT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!en_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (count_r <= CNT_ONE) begin
                    // A PRESET of 0 lands here too, so it behaves like 1
                    count_nxt_s = CNT_ZERO;
                    irq_set_s   = 1'b1;
                    state_nxt_s = ST_INT;
                end else begin
                    count_nxt_s = count_r - CNT_ONE;
                end
            end
            ST_INT: begin
                if (wr_ctrl_s && !merged_s[CTRL_EN_BIT]) begin
                    // Software disabling the timer overrides any reload
                    state_nxt_s = ST_IDLE;
                end else if (reload_s) begin
                    irq_clr_fsm_s = 1'b1;
                    state_nxt_s   = ST_LOAD;
                end else begin
                    en_clr_fsm_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and COUNT registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // CTRL register; a bus write takes priority over the one-shot EN clear
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (wr_ctrl_s) begin
            ctrl_r <= merged_s[CTRL_W-1:0];
        end else if (en_clr_fsm_s) begin
            ctrl_r[CTRL_EN_BIT] <= 1'b0;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // PRESET register; only consumed in LOAD, so mid-count writes wait for reload
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            preset_r <= PRESET_INIT;
        end else if (wr_preset_s) begin
            preset_r <= merged_s[CNT_W-1:0];
        end else begin
            preset_r <= preset_r;
        end
    end

    // Interrupt flag; a terminal count is never lost to a same-edge register write
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            irq_flag_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_flag_r <= 1'b1;
        end else if (wr_ctrl_s || wr_preset_s || irq_clr_fsm_s) begin
            irq_flag_r <= 1'b0;
        end else begin
            irq_flag_r <= irq_flag_r;
        end
    end

    // Read mux (Sel ignored) and masked interrupt output
    always_comb begin
        case (bus.Addr)
            ADDR_CTRL:   bus.RData = ctrl_ext_s;
            ADDR_PRESET: bus.RData = preset_ext_s;
            ADDR_COUNT:  bus.RData = count_ext_s;
            ADDR_RSVD:   bus.RData = 32'd0;
            default:     bus.RData = 32'd0;
        endcase
        bus.IRQ = irq_flag_r & ctrl_r[CTRL_IM_BIT];
    end

endmodule
